sk6805_rx: RTL and testbench

Single-wire SK6805 serial decoder. It samples the pulse-width-coded LED data line in the `clk_100MHz` domain and recovers each 24-bit GRB word. Each word is presented as 24-bit RGB with a one-cycle valid strobe, a per-frame pixel index and a frame-end pulse. It sits at the far end of the LED chain (loopback or daisy-chain output) and is the receive-side counterpart of the SK6805 driver; it is used for self-check and for forwarding colour data.

---
 rtl/sk6805_rx.sv | 164 ++++++++++++++++
 tb/tb_sk6805_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sk6805_rx.sv
// sk6805_rx: receive-side decoder for the SK6805 single-wire LED protocol.
// Measures high-pulse widths on the synchronised line, shifts GRB bits MSB
// first, and emits each 24-bit word as {R,G,B} with a valid strobe, a
// per-frame pixel index, frame-end pulses and protocol-error pulses.
module sk6805_rx #(
    parameter int T_MIN_HIGH   = 10,
    parameter int T_BIT_THRESH = 45,
    parameter int T_MAX_HIGH   = 150,
    parameter int T_RESET      = 8000
) (
    input  logic        clk_100MHz,
    input  logic        Rst,
    input  logic        LED_In,
    output logic [23:0] Data_Out,
    output logic        Data_Valid,
    output logic [7:0]  Pixel_Idx,
    output logic        Frame_Done,
    output logic        Err
);

    localparam logic [15:0] L_MIN    = 16'(T_MIN_HIGH);
    localparam logic [15:0] L_THRESH = 16'(T_BIT_THRESH);
    localparam logic [15:0] L_MAX    = 16'(T_MAX_HIGH);
    localparam logic [15:0] L_RESET  = 16'(T_RESET);

    typedef enum logic [1:0] {WAIT_GAP, IDLE, HIGH, LOW} state_t;

    state_t      r_state;
    logic [1:0]  r_sync;
    logic        r_s_d;      // edge-evaluated level of s, 3 cycles behind LED_In
    logic [15:0] r_high;
    logic [15:0] r_low;
    logic [23:0] r_sr;
    logic [4:0]  r_bitcnt;
    logic [7:0]  r_wcnt;     // index the next completed word will carry
    logic        r_any;      // at least one word completed in this frame
    logic [23:0] r_dout;
    logic        r_dv;
    logic [7:0]  r_pix;
    logic        r_fd;
    logic        r_err;

    logic [15:0] w_high_nxt;
    logic [15:0] w_low_nxt;
    logic        w_bit;
    logic [23:0] w_sr_nxt;

    // Saturating counter increments and the bit decision for the pulse just ended
    always_comb begin
        w_high_nxt = (r_high == 16'hFFFF) ? r_high : r_high + 16'd1;
        w_low_nxt  = (r_low  == 16'hFFFF) ? r_low  : r_low  + 16'd1;
        w_bit      = (r_high >= L_THRESH);
        w_sr_nxt   = {r_sr[22:0], w_bit};
    end

    // Synchroniser, edge register and decode FSM with registered outputs
    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            r_state  <= WAIT_GAP;
            r_sync   <= 2'b00;
            r_s_d    <= 1'b0;
            r_high   <= 16'd0;
            r_low    <= 16'd0;
            r_sr     <= 24'd0;
            r_bitcnt <= 5'd0;
            r_wcnt   <= 8'd0;
            r_any    <= 1'b0;
            r_dout   <= 24'd0;
            r_dv     <= 1'b0;
            r_pix    <= 8'd0;
            r_fd     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], LED_In};
            r_s_d  <= r_sync[1];
            r_dv   <= 1'b0;
            r_fd   <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                // Ignore everything until a full reset-length low is seen
                WAIT_GAP: begin
                    if (r_s_d) begin
                        r_low <= 16'd0;
                    end else begin
                        r_low <= w_low_nxt;
                        if (w_low_nxt >= L_RESET) begin
                            r_low   <= 16'd0;
                            r_state <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (r_s_d) begin
                        // the cycle that shows the rising edge is itself high
                        r_high  <= 16'd1;
                        r_state <= HIGH;
                    end
                end
                HIGH: begin
                    if (r_s_d) begin
                        r_high <= w_high_nxt;
                        if (w_high_nxt > L_MAX) begin
                            r_err    <= 1'b1;
                            r_low    <= 16'd0;
                            r_bitcnt <= 5'd0;
                            r_wcnt   <= 8'd0;
                            r_any    <= 1'b0;
                            r_pix    <= 8'd0;
                            r_state  <= WAIT_GAP;
                        end
                    end else if (r_high < L_MIN) begin
                        r_err    <= 1'b1;
                        r_low    <= 16'd0;
                        r_bitcnt <= 5'd0;
                        r_wcnt   <= 8'd0;
                        r_any    <= 1'b0;
                        r_pix    <= 8'd0;
                        r_state  <= WAIT_GAP;
                    end else begin
                        r_sr    <= w_sr_nxt;
                        r_low   <= 16'd0;
                        r_state <= LOW;
                        if (r_bitcnt == 5'd23) begin
                            r_bitcnt <= 5'd0;
                            r_dout   <= {w_sr_nxt[15:8], w_sr_nxt[23:16], w_sr_nxt[7:0]};
                            r_dv     <= 1'b1;
                            r_pix    <= r_wcnt;
                            r_wcnt   <= r_wcnt + 8'd1;
                            r_any    <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 5'd1;
                        end
                    end
                end
                LOW: begin
                    if (r_s_d) begin
                        r_high  <= 16'd1;
                        r_state <= HIGH;
                    end else begin
                        r_low <= w_low_nxt;
                        if (w_low_nxt >= L_RESET) begin
                            // a gap mid-word is an error; after whole words it ends the frame
                            if (r_bitcnt != 5'd0) r_err <= 1'b1;
                            else if (r_any)       r_fd  <= 1'b1;
                            r_bitcnt <= 5'd0;
                            r_wcnt   <= 8'd0;
                            r_any    <= 1'b0;
                            r_pix    <= 8'd0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= WAIT_GAP;
            endcase
        end
    end

    assign Data_Out   = r_dout;
    assign Data_Valid = r_dv;
    assign Pixel_Idx  = r_pix;
    assign Frame_Done = r_fd;
    assign Err        = r_err;

endmodule

// File: tb/tb_sk6805_rx.sv
// tb_sk6805_rx: directed stimulus with a scoreboard queue of expected words
// and an independent monitor that pops and compares on every Data_Valid.
module tb_sk6805_rx;

    localparam int TR  = 1000;
    localparam int GAP = TR + 100;

    logic        clk;
    logic        rst;
    logic        led;
    logic [23:0] dout;
    logic        dv;
    logic [7:0]  pix;
    logic        fd;
    logic        err;

    sk6805_rx #(.T_MIN_HIGH(10), .T_BIT_THRESH(45), .T_MAX_HIGH(150), .T_RESET(TR)) dut (
        .clk_100MHz (clk),
        .Rst        (rst),
        .LED_In     (led),
        .Data_Out   (dout),
        .Data_Valid (dv),
        .Pixel_Idx  (pix),
        .Frame_Done (fd),
        .Err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d;
        logic [7:0]  idx;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_err = 0;
    int   n_fd  = 0;
    int   e_err = 0;
    int   e_fd  = 0;

    // Monitor: compare each strobed word against the head of the queue
    always @(negedge clk) begin
        if (dv) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL dv_unexpected: got data=%06h idx=%0d, required no strobe", dout, pix);
            end else begin
                e = q.pop_front();
                if (dout !== e.d || pix !== e.idx) begin
                    bad++;
                    $display("FAIL word: got data=%06h idx=%0d, required data=%06h idx=%0d",
                             dout, pix, e.d, e.idx);
                end
            end
        end
        if (err) n_err++;
        if (fd)  n_fd++;
        if (err && (fd || dv)) begin
            total++;
            bad++;
            $display("FAIL exclusive: err=%0b fd=%0b dv=%0b, required err alone", err, fd, dv);
        end
    end

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Hold the line at a level for n sampled clock edges
    task automatic lvl(input logic v, input int n);
        led = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit_w(input int h);
        lvl(1'b1, h);
        lvl(1'b0, 125 - h);
    endtask

    task automatic send_bit(input logic b);
        send_bit_w(b ? 60 : 30);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_word(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b,
                             input logic [7:0] idx);
        exp_t e;
        e.d   = {r, g, b};
        e.idx = idx;
        q.push_back(e);
        send_byte(g);
        send_byte(r);
        send_byte(b);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dout"}, int'(dout), 0);
        chk({tag, "_dv"},   int'(dv),   0);
        chk({tag, "_pix"},  int'(pix),  0);
        chk({tag, "_fd"},   int'(fd),   0);
        chk({tag, "_err"},  int'(err),  0);
    endtask

    initial begin
        rst = 1'b1;
        led = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_outputs("rst0");
        rst = 1'b0;
        lvl(1'b0, GAP + 200);

        // single word, then frame end
        send_word(8'h34, 8'h12, 8'h56, 8'd0);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_word1", n_fd, e_fd);
        chk("err_word1", n_err, e_err);

        // two-word frame, then a new frame restarts at index 0
        send_word(8'h00, 8'hFF, 8'h00, 8'd0);
        send_word(8'h00, 8'h00, 8'hFF, 8'd1);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_frame2", n_fd, e_fd);
        send_word(8'hAA, 8'h55, 8'h0F, 8'd0);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_frame3", n_fd, e_fd);

        // partial word ended by a reset gap
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        lvl(1'b0, GAP);
        e_err++;
        chk("err_partial", n_err, e_err);
        chk("fd_partial", n_fd, e_fd);

        // short glitch, then ignored bits, then a gap and a clean word
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        lvl(1'b1, 5);
        lvl(1'b0, 60);
        e_err++;
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("err_glitch", n_err, e_err);
        lvl(1'b0, GAP);
        send_word(8'hC3, 8'h5A, 8'h81, 8'd0);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_glitch", n_fd, e_fd);
        chk("err_after_glitch", n_err, e_err);

        // overlong high pulse
        lvl(1'b1, 200);
        e_err++;
        lvl(1'b0, GAP);
        chk("err_long", n_err, e_err);

        // reset mid-word
        for (int i = 0; i < 12; i++) send_bit(1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_outputs("rst_mid");
        lvl(1'b0, GAP + 200);
        send_word(8'h01, 8'h80, 8'h7E, 8'd0);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_after_rst", n_fd, e_fd);

        // threshold boundary: 45 high decodes 1, 44 high decodes 0
        begin
            exp_t e;
            e.d   = 24'hAAAAAA;
            e.idx = 8'd0;
            q.push_back(e);
        end
        for (int i = 0; i < 24; i++) send_bit_w((i % 2 == 0) ? 45 : 44);
        lvl(1'b0, GAP);
        e_fd++;
        chk("fd_boundary", n_fd, e_fd);
        chk("err_final", n_err, e_err);
        chk("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
